// File: rtl/vector_mem_writer.sv
// Streams DEPTH word pairs into two memories at ascending addresses.
// Each accepted beat becomes one registered write strobe on both memory ports.
//
// state | meaning
// IDLE  | waiting for start_writing; s_ready low
// WRITE | accepting beats; one write per accepted beat
// DONE  | single cycle after the final beat; writing_done pulses
module vector_mem_writer #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int DEPTH        = VECTOR_WIDTH * DATA_WIDTH,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_writing,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data_a,
  input  logic [DATA_WIDTH-1:0] s_data_b,
  output logic                  s_ready,
  output logic                  wr_en_mem1,
  output logic                  wr_en_mem2,
  output logic [ADDR_WIDTH-1:0] wr_addr_mem1,
  output logic [ADDR_WIDTH-1:0] wr_addr_mem2,
  output logic [DATA_WIDTH-1:0] wr_data_mem1,
  output logic [DATA_WIDTH-1:0] wr_data_mem2,
  output logic                  writing_done,
  output logic                  busy,
  output logic [2:0]            element_count,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [2:0]            LAST_ELEM = 3'(VECTOR_WIDTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] beat_counter;
  logic [2:0]            elem_idx;
  logic                  accept;

  // abort must block acceptance in the same cycle it is raised
  assign s_ready = (state == WRITE) && !abort;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      beat_counter  <= '0;
      elem_idx      <= '0;
      element_count <= '0;
      wr_en_mem1    <= 1'b0;
      wr_en_mem2    <= 1'b0;
      wr_addr_mem1  <= '0;
      wr_addr_mem2  <= '0;
      wr_data_mem1  <= '0;
      wr_data_mem2  <= '0;
      writing_done  <= 1'b0;
      busy          <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      wr_en_mem1   <= accept;
      wr_en_mem2   <= accept;
      writing_done <= 1'b0;

      if (state == IDLE && s_valid) protocol_err <= 1'b1;

      // addr/data hold their last values when no beat is accepted
      if (accept) begin
        wr_addr_mem1  <= beat_counter;
        wr_addr_mem2  <= beat_counter;
        wr_data_mem1  <= s_data_a;
        wr_data_mem2  <= s_data_b;
        beat_counter  <= beat_counter + 1'b1;
        element_count <= elem_idx;
        elem_idx      <= (elem_idx == LAST_ELEM) ? 3'd0 : elem_idx + 3'd1;
      end

      case (state)
        IDLE: begin
          if (start_writing) begin
            state         <= WRITE;
            busy          <= 1'b1;
            beat_counter  <= '0;
            elem_idx      <= '0;
            element_count <= '0;
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (accept && beat_counter == LAST_ADDR) begin
            state        <= DONE;
            writing_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_writer.sv
// Directed self-checking bench for vector_mem_writer: loads, stalls, abort,
// ignored starts, IDLE protocol errors and mid-load reset.
module tb_vector_mem_writer;

  logic       clk;
  logic       rst_n;
  logic       start_writing;
  logic       abort;
  logic       s_valid;
  logic [7:0] s_data_a;
  logic [7:0] s_data_b;
  logic       s_ready;
  logic       wr_en_mem1, wr_en_mem2;
  logic [4:0] wr_addr_mem1, wr_addr_mem2;
  logic [7:0] wr_data_mem1, wr_data_mem2;
  logic       writing_done;
  logic       busy;
  logic [2:0] element_count;
  logic       protocol_err;

  int n_assert = 0;
  int n_fail   = 0;

  // strobe log filled by the monitor
  int         strobe_cnt = 0;
  int         done_cnt   = 0;
  logic [4:0] done_addr;
  logic       done_en;
  logic [4:0] rec_addr1 [512];
  logic [4:0] rec_addr2 [512];
  logic [7:0] rec_data1 [512];
  logic [7:0] rec_data2 [512];
  logic [2:0] rec_elem  [512];
  logic       rec_en2   [512];

  int b;
  int d;

  vector_mem_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_writing (start_writing),
    .abort         (abort),
    .s_valid       (s_valid),
    .s_data_a      (s_data_a),
    .s_data_b      (s_data_b),
    .s_ready       (s_ready),
    .wr_en_mem1    (wr_en_mem1),
    .wr_en_mem2    (wr_en_mem2),
    .wr_addr_mem1  (wr_addr_mem1),
    .wr_addr_mem2  (wr_addr_mem2),
    .wr_data_mem1  (wr_data_mem1),
    .wr_data_mem2  (wr_data_mem2),
    .writing_done  (writing_done),
    .busy          (busy),
    .element_count (element_count),
    .protocol_err  (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en_mem1 || wr_en_mem2) begin
      if (strobe_cnt < 512) begin
        rec_addr1[strobe_cnt] = wr_addr_mem1;
        rec_addr2[strobe_cnt] = wr_addr_mem2;
        rec_data1[strobe_cnt] = wr_data_mem1;
        rec_data2[strobe_cnt] = wr_data_mem2;
        rec_elem[strobe_cnt]  = element_count;
        rec_en2[strobe_cnt]   = wr_en_mem2 && wr_en_mem1;
      end
      strobe_cnt++;
    end
    if (writing_done) begin
      done_cnt++;
      done_addr = wr_addr_mem1;
      done_en   = wr_en_mem1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat_a(input int mode, input int i);
    case (mode)
      0:       return 8'(i);
      1:       return 8'(i + 64);
      2:       return 8'(255 - i);
      default: return 8'(i * 3 + 7);
    endcase
  endfunction

  function automatic logic [7:0] pat_b(input int mode, input int i);
    case (mode)
      0:       return 8'(2 * i);
      1:       return 8'(i) ^ 8'h55;
      2:       return 8'(i + 3);
      default: return 8'(200 - i);
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start_writing = 1'b1;
    tick();
    start_writing = 1'b0;
  endtask

  task automatic drive_beats(input int mode, input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      s_valid  = 1'b1;
      s_data_a = pat_a(mode, i);
      s_data_b = pat_b(mode, i);
      tick();
      s_valid = 1'b0;
      if (gaps) tick();
    end
  endtask

  task automatic verify_load(input string tag, input int base, input int n, input int mode);
    check({tag, "_strobes"}, strobe_cnt - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < 512) begin
        check({tag, "_addr1"}, rec_addr1[base+i], i);
        check({tag, "_addr2"}, rec_addr2[base+i], i);
        check({tag, "_data1"}, rec_data1[base+i], pat_a(mode, i));
        check({tag, "_data2"}, rec_data2[base+i], pat_b(mode, i));
        check({tag, "_elem"},  rec_elem[base+i],  i % 4);
        check({tag, "_en2"},   rec_en2[base+i],   1);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    start_writing = 1'b0;
    abort         = 1'b0;
    s_valid       = 1'b0;
    s_data_a      = '0;
    s_data_b      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en1", wr_en_mem1, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_done", writing_done, 0);
    check("rst_perr", protocol_err, 0);
    check("rst_addr1", wr_addr_mem1, 0);
    check("rst_elem", element_count, 0);
    rst_n = 1'b1;
    tick();

    // continuous load
    b = strobe_cnt; d = done_cnt;
    do_start();
    check("cont_ready", s_ready, 1);
    drive_beats(0, 0, 31, 0);
    check("cont_done_pulse", writing_done, 1);
    check("cont_done_addr", wr_addr_mem1, 31);
    check("cont_busy_done", busy, 1);
    tick();
    check("cont_busy_low", busy, 0);
    check("cont_done_clear", writing_done, 0);
    tick();
    verify_load("cont", b, 32, 0);
    check("cont_done_cnt", done_cnt - d, 1);
    check("cont_done_maddr", done_addr, 31);
    check("cont_done_en", done_en, 1);

    // stalled load, s_valid alternating
    b = strobe_cnt; d = done_cnt;
    do_start();
    drive_beats(1, 0, 4, 1);
    drive_beats(1, 5, 5, 0);
    tick();
    check("stall_en_low", wr_en_mem1, 0);
    check("stall_addr_hold", wr_addr_mem1, 5);
    check("stall_data_hold", wr_data_mem1, pat_a(1, 5));
    drive_beats(1, 6, 31, 1);
    tick();
    verify_load("stall", b, 32, 1);
    check("stall_done_cnt", done_cnt - d, 1);

    // abort at beat 10
    b = strobe_cnt; d = done_cnt;
    do_start();
    drive_beats(2, 0, 9, 0);
    s_valid  = 1'b1;
    s_data_a = pat_a(2, 10);
    s_data_b = pat_b(2, 10);
    abort    = 1'b1;
    #1;
    check("abort_ready", s_ready, 0);
    tick();
    s_valid = 1'b0;
    abort   = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_no_strobe", wr_en_mem1, 0);
    tick(); tick();
    verify_load("abort", b, 10, 2);
    check("abort_done_cnt", done_cnt - d, 0);

    // abort coincident with the final beat
    b = strobe_cnt; d = done_cnt;
    do_start();
    drive_beats(0, 0, 30, 0);
    s_valid  = 1'b1;
    s_data_a = pat_a(0, 31);
    s_data_b = pat_b(0, 31);
    abort    = 1'b1;
    tick();
    s_valid = 1'b0;
    abort   = 1'b0;
    tick(); tick();
    check("abort_last_strobes", strobe_cnt - b, 31);
    check("abort_last_done", done_cnt - d, 0);
    check("abort_last_busy", busy, 0);

    // start together with abort in IDLE starts the load
    b = strobe_cnt; d = done_cnt;
    start_writing = 1'b1;
    abort         = 1'b1;
    tick();
    start_writing = 1'b0;
    abort         = 1'b0;
    check("start_abort_busy", busy, 1);
    drive_beats(3, 0, 31, 0);
    tick(); tick();
    verify_load("fresh", b, 32, 3);
    check("fresh_done_cnt", done_cnt - d, 1);

    // start pulses during WRITE and DONE are ignored
    b = strobe_cnt; d = done_cnt;
    do_start();
    drive_beats(1, 0, 11, 0);
    start_writing = 1'b1;
    drive_beats(1, 12, 12, 0);
    start_writing = 1'b0;
    drive_beats(1, 13, 31, 0);
    check("ign_done_pulse", writing_done, 1);
    start_writing = 1'b1;
    tick();
    start_writing = 1'b0;
    check("ign_busy_after_done", busy, 0);
    tick();
    check("ign_busy_idle", busy, 0);
    verify_load("ign", b, 32, 1);
    check("ign_done_cnt", done_cnt - d, 1);

    // s_valid while IDLE
    b = strobe_cnt;
    check("idle_perr_before", protocol_err, 0);
    s_valid = 1'b1;
    #1;
    check("idle_ready", s_ready, 0);
    tick();
    check("idle_perr_set", protocol_err, 1);
    s_valid = 1'b0;
    tick(); tick();
    check("idle_perr_sticky", protocol_err, 1);
    check("idle_no_strobe", strobe_cnt - b, 0);
    check("idle_busy", busy, 0);
    rst_n = 1'b0;
    #1;
    check("idle_perr_reset", protocol_err, 0);
    rst_n = 1'b1;
    tick();

    // reset asserted during beat 20
    do_start();
    drive_beats(0, 0, 19, 0);
    s_valid  = 1'b1;
    s_data_a = pat_a(0, 20);
    s_data_b = pat_b(0, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en1", wr_en_mem1, 0);
    check("mid_rst_en2", wr_en_mem2, 0);
    check("mid_rst_addr1", wr_addr_mem1, 0);
    check("mid_rst_addr2", wr_addr_mem2, 0);
    check("mid_rst_data1", wr_data_mem1, 0);
    check("mid_rst_data2", wr_data_mem2, 0);
    check("mid_rst_done", writing_done, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_elem", element_count, 0);
    check("mid_rst_perr", protocol_err, 0);
    s_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_busy", busy, 0);
    b = strobe_cnt; d = done_cnt;
    do_start();
    drive_beats(2, 0, 31, 0);
    tick(); tick();
    verify_load("post_rst", b, 32, 2);
    check("post_rst_done_cnt", done_cnt - d, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_mem_writer.md
VECTOR_MEM_WRITER -- requirements
Module: vector_mem_writer

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 8, element width; VECTOR_WIDTH, 4, elements per vector; DEPTH, VECTOR_WIDTH*DATA_WIDTH, words per memory; ADDR_WIDTH, 5, memory address width.
REQ-002 Ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start_writing  in  1  begin a load of DEPTH word pairs.
- abort  in  1  synchronous cancel of a load in progress.
- s_valid  in  1  input beat valid.
- s_data_a  in  DATA_WIDTH  word for mem1.
- s_data_b  in  DATA_WIDTH  word for mem2.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- wr_en_mem1, wr_en_mem2  out  1  memory write strobes.
- wr_addr_mem1, wr_addr_mem2  out  ADDR_WIDTH  write addresses.
- wr_data_mem1, wr_data_mem2  out  DATA_WIDTH  write data.
- writing_done  out  1  one-cycle pulse, load complete.
- busy  out  1  high in WRITE or DONE.
- element_count  out  3  element index within the current vector of the last accepted beat.
- protocol_err  out  1  sticky; s_valid seen while s_ready low and state IDLE.

Function
REQ-003 FSM has three states: IDLE, WRITE and DONE; the reset state is IDLE.
REQ-004 In IDLE, start_writing=1 moves the FSM to WRITE at the next edge and clears beat_counter and element_count.
REQ-005 s_ready is combinational: 1 only when state=WRITE and abort=0; 0 in IDLE and DONE.
REQ-006 An accepted beat at cycle N drives wr_en_mem1=wr_en_mem2=1 in cycle N+1, with wr_addr_mem1=wr_addr_mem2=beat_counter value at N, wr_data_mem1=s_data_a(N) and wr_data_mem2=s_data_b(N), all registered.
REQ-007 In any cycle following a non-accepted cycle, wr_en_mem1/2 are 0, and addr/data hold their last values.
REQ-008 beat_counter (ADDR_WIDTH bits) increments by 1 per accepted beat; no increment without acceptance (s_valid gaps are stalls).
REQ-009 element_count increments per accepted beat and wraps from VECTOR_WIDTH-1 to 0.
REQ-010 Acceptance of the beat with beat_counter=DEPTH-1 moves the FSM to DONE and sets writing_done=1 for the following cycle, coincident with the final write strobe.
REQ-011 DONE lasts exactly one cycle and then returns to IDLE; start_writing is ignored in DONE and WRITE.
REQ-012 abort=1 in WRITE returns the FSM to IDLE at the next edge: no beat is accepted that cycle, writing_done is not pulsed, and a write already registered from the previous cycle still completes.
REQ-013 When abort=1 and the final beat would coincide in the same cycle, abort wins: the beat is not accepted and writing_done is not pulsed.
REQ-014 start_writing and abort asserted together in IDLE: abort is ignored and the load starts.
REQ-015 protocol_err sets when s_valid=1 in IDLE and clears only on reset.
REQ-016 busy is 1 when state is WRITE or DONE, registered from the state.
REQ-017 No address wrap occurs: DEPTH writes to addresses 0..DEPTH-1 in ascending order, each exactly once per completed load.

Reset
REQ-018 rst_n low asynchronously forces: state IDLE; s_ready, wr_en_mem1/2, writing_done, busy and protocol_err to 0; wr_addr/wr_data, beat_counter and element_count to 0.
REQ-019 Reset mid-load discards progress; after release the block waits in IDLE for a new start_writing.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Continuous load: start, 32 back-to-back beats a=i, b=2i -> wr_en high 32 cycles, addr 0..31, data match, writing_done one pulse with addr 31, busy low 2 cycles after last beat.
- Stalled load: s_valid toggling 1/0 -> exactly 32 strobes, no addr skips or repeats, element_count sequence 0,1,2,3,0...
- Abort at beat 10 -> addr 0..9 written (strobe for 9 after abort cycle allowed), no writing_done, then a fresh start writes addr 0..31.
- Start ignored while busy: start pulses during WRITE and DONE -> no counter reset, single writing_done.
- s_valid in IDLE -> s_ready 0, no strobe, protocol_err=1 until reset.
- Reset asserted at beat 20 -> all outputs 0 immediately; after release a new load completes with addr 0..31.
